// File: rtl/hazard_scoreboard.sv
// Per-register countdown scoreboard for load-use, branch, WAW and multiplier hazards.
// Stalls the instruction in IF/ID until every operand it needs can be forwarded.
module hazard_scoreboard #(
    parameter int NREG     = 32,
    parameter int AW       = 5,
    parameter int ALU_LAT  = 1,
    parameter int LOAD_LAT = 2,
    parameter int MUL_LAT  = 4,
    parameter int CW       = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id_valid,
    input  logic [AW-1:0] id_rs,
    input  logic [AW-1:0] id_rt,
    input  logic          id_use_rs,
    input  logic          id_use_rt,
    input  logic          id_early,
    input  logic          id_regwrite,
    input  logic [AW-1:0] id_rd,
    input  logic [1:0]    id_class,
    input  logic          flush,
    output logic          pc_write,
    output logic          ifid_write,
    output logic          hold,
    output logic [15:0]   stall_count
);

    // Register 0 is never tracked, so the array starts at 1.
    logic [CW-1:0] cnt_q [1:NREG-1];
    logic [CW-1:0] cnt_d [1:NREG-1];
    logic [CW-1:0] mul_busy_q, mul_busy_d;
    logic [15:0]   stall_count_q, stall_count_d;

    logic [CW-1:0] lat;
    logic [CW-1:0] rs_cnt, rt_cnt, rd_cnt;
    logic          rs_haz, rt_haz, waw_haz, mul_haz;
    logic          stall, issue;

    always_comb begin
        case (id_class)
            2'd1:    lat = CW'(LOAD_LAT);
            2'd2:    lat = CW'(MUL_LAT);
            default: lat = CW'(ALU_LAT);
        endcase
    end

    // Index 0 is left out of the loop, so reads of r0 return zero.
    always_comb begin
        rs_cnt = '0;
        rt_cnt = '0;
        rd_cnt = '0;
        for (int r = 1; r < NREG; r++) begin
            if (id_rs == AW'(r)) rs_cnt = cnt_q[r];
            if (id_rt == AW'(r)) rt_cnt = cnt_q[r];
            if (id_rd == AW'(r)) rd_cnt = cnt_q[r];
        end
    end

    // An EX-stage consumer can take the value forwarded in the producer's last cycle.
    always_comb begin
        rs_haz  = id_use_rs && (id_rs != '0) &&
                  (id_early ? (rs_cnt != '0) : (rs_cnt > CW'(1)));
        rt_haz  = id_use_rt && (id_rt != '0) &&
                  (id_early ? (rt_cnt != '0) : (rt_cnt > CW'(1)));
        waw_haz = id_regwrite && (id_rd != '0) && (rd_cnt > lat);
        mul_haz = (id_class == 2'd2) && (mul_busy_q != '0);
        stall   = id_valid && !flush && (rs_haz || rt_haz || waw_haz || mul_haz);
        issue   = id_valid && !flush && !stall;
    end

    always_comb begin
        for (int r = 1; r < NREG; r++) begin
            cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - CW'(1) : '0;
            if (issue && id_regwrite && (id_rd == AW'(r))) cnt_d[r] = lat;
        end
        mul_busy_d = (mul_busy_q != '0) ? mul_busy_q - CW'(1) : '0;
        if (issue && (id_class == 2'd2)) mul_busy_d = CW'(MUL_LAT);
        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != 16'hFFFF)) stall_count_d = stall_count_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 1; r < NREG; r++) cnt_q[r] <= '0;
            mul_busy_q    <= '0;
            stall_count_q <= '0;
        end else begin
            for (int r = 1; r < NREG; r++) cnt_q[r] <= cnt_d[r];
            mul_busy_q    <= mul_busy_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign pc_write    = !stall;
    assign ifid_write  = !stall;
    assign hold        = stall;
    assign stall_count = stall_count_q;

endmodule
